// File: rtl/ofifo_drain.sv
// ofifo_drain: pops partial-sum vectors from the corelet OFIFO and writes them to psum SRAM
// at consecutive (wrapping) addresses from a programmable base. Write latency is 2 cycles from ofifo_rd.
// Backpressure: pops only while ofifo_valid is high; gaps in ofifo_valid give matching gaps in writes.
`timescale 1ns/1ps
module ofifo_drain #(
  parameter int PSUM_BW = 16,
  parameter int COL     = 8,
  parameter int ADDR_BW = 11,
  parameter int CNT_BW  = 11
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [ADDR_BW-1:0]     base_addr_i,
  input  logic [CNT_BW-1:0]      num_vec_i,
  input  logic                   ofifo_valid_i,
  output logic                   ofifo_rd_o,
  input  logic [PSUM_BW*COL-1:0] psum_in_i,
  output logic                   sram_cen_o,
  output logic                   sram_wen_o,
  output logic [ADDR_BW-1:0]     sram_addr_o,
  output logic [PSUM_BW*COL-1:0] sram_d_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_BW-1:0]      wr_count_o
);

  localparam int DW = PSUM_BW * COL;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_BW-1:0]  addr_q, addr_d;          // next SRAM address to write
  logic [CNT_BW-1:0]   remain_q, remain_d;      // pops still to issue
  logic                pend_q, pend_d;          // a pop was issued last cycle; psum_in is valid now
  logic                sram_cen_q, sram_cen_d;
  logic                sram_wen_q, sram_wen_d;
  logic [ADDR_BW-1:0]  sram_addr_q, sram_addr_d;
  logic [DW-1:0]       sram_d_q, sram_d_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_BW-1:0]   wr_count_q, wr_count_d;
  logic                pop;

  // Pop request is combinational so a vector can be drained every cycle.
  assign pop = (state_q == DRAIN) && ofifo_valid_i && (remain_q != '0);

  assign ofifo_rd_o  = pop;
  assign sram_cen_o  = sram_cen_q;
  assign sram_wen_o  = sram_wen_q;
  assign sram_addr_o = sram_addr_q;
  assign sram_d_o    = sram_d_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wr_count_o  = wr_count_q;

  // Next-state: job control, pop accounting and the registered SRAM write stage.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    pend_d      = pop;
    sram_cen_d  = 1'b1;
    sram_wen_d  = 1'b1;
    sram_addr_d = sram_addr_q;
    sram_d_d    = sram_d_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_count_d  = wr_count_q;

    // Data popped last cycle is on psum_in now; write it straight through.
    if (pend_q) begin
      sram_cen_d  = 1'b0;
      sram_wen_d  = 1'b0;
      sram_addr_d = addr_q;
      sram_d_d    = psum_in_i;
      addr_d      = addr_q + ADDR_BW'(1);
      wr_count_d  = wr_count_q + CNT_BW'(1);
    end

    // busy stays up through the done cycle and drops right after it.
    if (done_q) begin
      busy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // busy_q is still high in the done cycle, so a start there is ignored.
        if (start_i && !busy_q) begin
          addr_d     = base_addr_i;
          remain_d   = num_vec_i;
          wr_count_d = '0;
          busy_d     = 1'b1;
          state_d    = (num_vec_i == '0) ? FLUSH : DRAIN;
        end
      end
      DRAIN: begin
        if (pop) begin
          remain_d = remain_q - CNT_BW'(1);
          if (remain_q == CNT_BW'(1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Only one pop can be in flight, and it is written this cycle,
        // so done lands together with the last write.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous abort on reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      pend_q      <= 1'b0;
      sram_cen_q  <= 1'b1;
      sram_wen_q  <= 1'b1;
      sram_addr_q <= '0;
      sram_d_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      pend_q      <= pend_d;
      sram_cen_q  <= sram_cen_d;
      sram_wen_q  <= sram_wen_d;
      sram_addr_q <= sram_addr_d;
      sram_d_q    <= sram_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_count_q  <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_ofifo_drain.sv
// Testbench for ofifo_drain: directed jobs driven cycle by cycle, with the OFIFO modelled by the bench.
// Every expected SRAM write (address, data, cycle) is queued at pop time and checked when due.
// Also checks ofifo_rd, busy, done and wr_count every cycle against a small job model.
`timescale 1ns/1ps
module tb_ofifo_drain;
  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int ADDR_BW = 11;
  localparam int CNT_BW  = 11;
  localparam int DW      = PSUM_BW * COL;

  typedef struct {
    logic [ADDR_BW-1:0] addr;
    logic [DW-1:0]      data;
    int                 cyc;
  } wr_t;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                start_i;
  logic [ADDR_BW-1:0]  base_addr_i;
  logic [CNT_BW-1:0]   num_vec_i;
  logic                ofifo_valid_i;
  logic                ofifo_rd_o;
  logic [DW-1:0]       psum_in_i;
  logic                sram_cen_o;
  logic                sram_wen_o;
  logic [ADDR_BW-1:0]  sram_addr_o;
  logic [DW-1:0]       sram_d_o;
  logic                busy_o;
  logic                done_o;
  logic [CNT_BW-1:0]   wr_count_o;

  ofifo_drain #(
    .PSUM_BW(PSUM_BW), .COL(COL), .ADDR_BW(ADDR_BW), .CNT_BW(CNT_BW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .num_vec_i(num_vec_i),
    .ofifo_valid_i(ofifo_valid_i), .ofifo_rd_o(ofifo_rd_o), .psum_in_i(psum_in_i),
    .sram_cen_o(sram_cen_o), .sram_wen_o(sram_wen_o), .sram_addr_o(sram_addr_o),
    .sram_d_o(sram_d_o), .busy_o(busy_o), .done_o(done_o), .wr_count_o(wr_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Scoreboard and job model.
  wr_t                exp_q[$];
  int                 cyc       = 0;
  int                 pops_left = 0;
  int                 done_due  = -10;
  bit                 busy_m    = 1'b0;
  int                 wr_m      = 0;
  int                 wr_seen   = 0;
  logic [ADDR_BW-1:0] next_addr = '0;
  logic [ADDR_BW-1:0] last_addr = '0;
  logic [DW-1:0]      last_data = '0;
  logic [DW-1:0]      pend      = '0;
  bit                 pend_v    = 1'b0;

  // Stimulus for the next cycle.
  bit                 st_v   = 1'b0;
  logic [ADDR_BW-1:0] base_v = '0;
  logic [CNT_BW-1:0]  num_v  = '0;
  bit                 vld_v  = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at posedge+1: drive one cycle, check outputs, advance model, move to next posedge+1.
  task automatic run_cycle();
    bit  exp_wr;
    bit  exp_rd;
    wr_t e;
    logic [DW-1:0] v;
    start_i       = st_v;
    base_addr_i   = base_v;
    num_vec_i     = num_v;
    ofifo_valid_i = vld_v;
    psum_in_i     = pend_v ? pend : rnd();
    pend_v        = 1'b0;
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    exp_wr = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (exp_wr) begin
      e = exp_q.pop_front();
      last_addr = e.addr;
      last_data = e.data;
      wr_m++;
    end
    if (sram_cen_o === 1'b0) wr_seen++;
    exp_rd = (pops_left > 0) && vld_v;
    chk("ofifo_rd", ofifo_rd_o, exp_rd);
    chk("sram_cen", sram_cen_o, !exp_wr);
    chk("sram_wen", sram_wen_o, !exp_wr);
    chk("sram_addr", sram_addr_o, last_addr);
    chk("sram_d", sram_d_o, last_data);
    chk("busy", busy_o, busy_m);
    chk("done", done_o, cyc == done_due);
    chk("wr_count", wr_count_o, wr_m);
    if (exp_rd) begin
      v = rnd();
      exp_q.push_back('{addr: next_addr, data: v, cyc: cyc + 2});
      pend      = v;
      pend_v    = 1'b1;
      next_addr = next_addr + ADDR_BW'(1);
      pops_left--;
      if (pops_left == 0) done_due = cyc + 2;
    end
    if (cyc == done_due) begin
      busy_m = 1'b0;
    end else if (st_v && !busy_m) begin
      busy_m    = 1'b1;
      pops_left = int'(num_v);
      next_addr = base_v;
      wr_m      = 0;
      if (num_v == '0) done_due = cyc + 2;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Asynchronous reset from mid-cycle; outputs must clear before any clock edge.
  task automatic reset_pulse();
    reset_i = 1'b1;
    #1;
    chk("rst_ofifo_rd", ofifo_rd_o, 1'b0);
    chk("rst_sram_cen", sram_cen_o, 1'b1);
    chk("rst_sram_wen", sram_wen_o, 1'b1);
    chk("rst_sram_addr", sram_addr_o, '0);
    chk("rst_sram_d", sram_d_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_wr_count", wr_count_o, '0);
    exp_q.delete();
    pops_left = 0;
    busy_m    = 1'b0;
    done_due  = -10;
    wr_m      = 0;
    last_addr = '0;
    last_data = '0;
    pend_v    = 1'b0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    cyc++;
  endtask

  task automatic start_job(input int base, input int num, input bit vld);
    st_v   = 1'b1;
    base_v = ADDR_BW'(base);
    num_v  = CNT_BW'(num);
    vld_v  = vld;
    run_cycle();
    st_v = 1'b0;
  endtask

  initial begin
    reset_i       = 1'b1;
    start_i       = 1'b0;
    base_addr_i   = '0;
    num_vec_i     = '0;
    ofifo_valid_i = 1'b0;
    psum_in_i     = '0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_pulse();
    repeat (2) run_cycle();

    // Basic job: 4 vectors from address 5, then a start in the done cycle
    // and ofifo_valid left high afterwards (both must be ignored).
    start_job(5, 4, 1'b1);
    repeat (5) run_cycle();
    start_job(300, 2, 1'b1);
    repeat (4) run_cycle();
    chk("basic_wr_count", wr_count_o, 4);
    chk("basic_last_addr", sram_addr_o, 8);
    vld_v = 1'b0;
    run_cycle();

    // Bubbles: valid pattern 1,0,0,1,1.
    start_job(40, 3, 1'b0);
    vld_v = 1'b1; run_cycle();
    vld_v = 1'b0; run_cycle();
    run_cycle();
    vld_v = 1'b1; run_cycle();
    run_cycle();
    vld_v = 1'b0;
    repeat (4) run_cycle();

    // Address wrap at 2^ADDR_BW.
    start_job(2046, 3, 1'b1);
    repeat (6) run_cycle();
    chk("wrap_last_addr", sram_addr_o, 0);
    vld_v = 1'b0;
    run_cycle();

    // Zero-length job: done two cycles after start, no SRAM access.
    start_job(77, 0, 1'b0);
    repeat (3) run_cycle();

    // A start mid-job must not disturb the running job.
    start_job(200, 5, 1'b1);
    repeat (2) run_cycle();
    start_job(100, 7, 1'b1);
    repeat (6) run_cycle();
    chk("ignored_wr_count", wr_count_o, 5);
    vld_v = 1'b0;
    run_cycle();

    // Reset after 2 of 6 writes, then a clean job.
    start_job(10, 6, 1'b1);
    wr_seen = 0;
    for (int k = 0; k < 20 && wr_seen < 2; k++) run_cycle();
    chk("mid_writes_seen", wr_seen, 2);
    vld_v = 1'b0;
    reset_pulse();
    run_cycle();
    start_job(0, 2, 1'b1);
    repeat (5) run_cycle();
    chk("post_reset_wr_count", wr_count_o, 2);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofifo_drain.md
Name: ofifo_drain

Overview:
- Downstream neighbour of the corelet.
- Pops completed partial-sum vectors from the corelet OFIFO and writes each one into the psum SRAM at consecutive addresses from a programmable base.
- Runs one drain job per start pulse and signals completion.
- Lets the top-level controller overlap MAC execution with OFIFO drain without tracking addresses itself.

Parameters:
psum_bw, 16, width of one partial sum
col, 8, number of partial sums per OFIFO vector
addr_bw, 11, psum SRAM address width
cnt_bw, 11, width of the vector-count field

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; latches base_addr and num_vec and begins a job
base_addr  input  addr_bw  first SRAM address of the job
num_vec  input  cnt_bw  number of vectors to drain
ofifo_valid  input  1  OFIFO holds at least one vector
ofifo_rd  output  1  OFIFO pop request
psum_in  input  psum_bw*col  OFIFO read data, valid the cycle after ofifo_rd
sram_cen  output  1  SRAM chip enable, active low
sram_wen  output  1  SRAM write enable, active low
sram_addr  output  addr_bw  SRAM address
sram_d  output  psum_bw*col  SRAM write data
busy  output  1  job in progress
done  output  1  one-cycle pulse when the job's last write is issued
wr_count  output  cnt_bw  writes issued in the current or last job

Behaviour:
- Reset (async, active-high) values:
  - ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0, busy=0, done=0, wr_count=0.
  - State=IDLE; all counters cleared.
- States: IDLE, DRAIN, FLUSH.
- IDLE:
  - start=1 latches base_addr into the address counter and num_vec into the remaining-pop counter.
  - Clears wr_count and sets busy=1 next cycle.
  - If num_vec=0: go straight to FLUSH; done pulses the following cycle with no SRAM access.
  - Otherwise go to DRAIN.
- DRAIN:
  - ofifo_rd = ofifo_valid AND remaining_pops>0. This is combinational from registered state and ofifo_valid, and is never asserted outside DRAIN.
  - Each pop decrements remaining_pops.
  - When a pop brings remaining_pops to 0, go to FLUSH next cycle.
- Read pipeline: pop at cycle t, then psum_in is captured at the cycle t+1 edge.
- Write stage (registered, latency 2 from ofifo_rd):
  - At cycle t+2: sram_cen=0, sram_wen=0, sram_addr=current address, sram_d=captured psum_in.
  - Address increments after each write and wraps modulo 2^addr_bw with no error.
  - wr_count increments on each write.
  - Without a write: sram_cen=1 and sram_wen=1; sram_addr and sram_d hold their last values.
- Throughput: one vector per cycle while ofifo_valid stays high. Gaps in ofifo_valid produce matching gaps in writes, with no reordering.
- FLUSH:
  - Waits until the in-flight pipeline is empty.
  - done=1 for exactly one cycle, coincident with the last write (sram_cen=0). For num_vec=0, done comes one cycle after entering FLUSH.
  - busy drops the cycle after done; return to IDLE.
- start while busy=1 is ignored and does not disturb the job.
- start in the same cycle that done pulses is also ignored; a new job needs busy=0.
- reset mid-job:
  - Aborts immediately and all outputs return to reset values.
  - A pop already issued is lost; the OFIFO owner resets on the same signal.
- wr_count holds its final value after a job until the next accepted start.
- sram_d lane mapping matches psum_in bit for bit: column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].

Test Plan:
- Basic job: base_addr=5, num_vec=4, ofifo_valid held high, psum_in values V0..V3 → ofifo_rd high 4 consecutive cycles; writes to addresses 5,6,7,8 at latency 2 with sram_d=V0..V3; done pulses with the write to 8; wr_count=4; busy low the next cycle.
- Bubbles: num_vec=3, ofifo_valid pattern 1,0,0,1,1 → exactly 3 pops, writes to base..base+2 in order with the 2-cycle gap preserved; ofifo_rd never high while ofifo_valid=0.
- Wrap: addr_bw=11, base_addr=2046, num_vec=3 → writes to addresses 2046, 2047, 0.
- Zero and ignored starts: num_vec=0 → done after 2 cycles with sram_cen never low. A second start mid-job (base=100) → no effect; the first job's addresses continue.
- Reset mid-job: assert reset after 2 of 6 writes → all outputs at reset values within the same cycle (asynchronous). A new job after reset (base=0, num_vec=2) runs cleanly to done with wr_count=2.
- Extra data: ofifo_valid stays high after the job completes → ofifo_rd stays 0 once remaining_pops=0; no extra writes.
